// File: rtl/das_beamformer.sv
// Delay-and-sum beamformer: NCH ring buffers aligned by per-channel integer delay, summed at full precision.
// Two-cycle latency, 1 sample/cycle, no backpressure; optional per-channel mask under `DAS_CHMASK_EN.
module das_beamformer #(
  parameter int NCH   = 20,
  parameter int W     = 16,
  parameter int DEPTH = 32,
  parameter int DW    = $clog2(DEPTH),
  parameter int CW    = $clog2(NCH)
) (
  input  logic             CLKDIVH2,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [NCH*W-1:0] in_data,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [DW-1:0]    cfg_delay,
`ifdef DAS_CHMASK_EN
  input  logic             cfg_en,
`endif
  output logic             out_valid,
  output logic [W+CW:0]    out_data
);

  localparam int OW = W + CW + 1;

  logic [W-1:0]  ram_q   [NCH][DEPTH];
  logic [DW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] delay_q [NCH];
  logic [W-1:0]  tap_d   [NCH];
  logic [W-1:0]  tap_q   [NCH];
  logic          s1_vld_q;
  logic [OW-1:0] sum_d;
  logic          out_valid_q;
  logic [OW-1:0] out_data_q;
`ifdef DAS_CHMASK_EN
  logic [NCH-1:0] en_q;
`endif

  always_comb begin
    wptr_d = wptr_q + 1'b1;
    fill_d = (fill_q == DW'(DEPTH - 1)) ? fill_q : fill_q + 1'b1;
  end

  // fill counts samples already stored, so a delay beyond it would read stale RAM
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      tap_d[c] = '0;
      if (delay_q[c] == '0) begin
        tap_d[c] = in_data[c*W +: W];
      end else if (delay_q[c] <= fill_q) begin
        tap_d[c] = ram_q[c][wptr_q - delay_q[c]];
      end
`ifdef DAS_CHMASK_EN
      if (!en_q[c]) begin
        tap_d[c] = '0;
      end
`endif
    end
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NCH; c++) begin
      sum_d = sum_d + {{(OW-W){tap_q[c][W-1]}}, tap_q[c]};
    end
  end

  always_ff @(posedge CLKDIVH2) begin
    if (in_valid) begin
      for (int c = 0; c < NCH; c++) begin
        ram_q[c][wptr_q] <= in_data[c*W +: W];
      end
    end
  end

  always_ff @(posedge CLKDIVH2 or posedge RST) begin
    if (RST) begin
      wptr_q      <= '0;
      fill_q      <= '0;
      s1_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        delay_q[c] <= '0;
        tap_q[c]   <= '0;
      end
`ifdef DAS_CHMASK_EN
      en_q <= '1;
`endif
    end else begin
      if (in_valid) begin
        wptr_q <= wptr_d;
        fill_q <= fill_d;
        for (int c = 0; c < NCH; c++) begin
          tap_q[c] <= tap_d[c];
        end
      end
      // Channel indices at or above NCH match no register, so such writes fall away
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && (cfg_ch == CW'(c))) begin
          delay_q[c] <= cfg_delay;
`ifdef DAS_CHMASK_EN
          en_q[c]    <= cfg_en;
`endif
        end
      end
      s1_vld_q    <= in_valid;
      out_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_data_q <= sum_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_das_beamformer.sv
// Directed bench for das_beamformer (NCH=4, W=16, DEPTH=8) plus an NCH=5 instance for out-of-range cfg writes.
module tb_das_beamformer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [2:0]  cfg_delay;
  logic        cfg_en;
  logic        out_valid;
  logic [18:0] out_data;

  logic [79:0] in_data2;
  logic        cfg_we2;
  logic [2:0]  cfg_ch2;
  logic [2:0]  cfg_delay2;
  logic        cfg_en2;
  logic        out_valid2;
  logic [19:0] out_data2;

  int errors = 0;
  int checks = 0;
  logic pv1, pv2;
  int   pe1, pe2, pe1b, pe2b, last, last2;
  logic [18:0] e19;
  logic [19:0] e20;

  always #5 clk = ~clk;

  das_beamformer #(.NCH(4), .W(16), .DEPTH(8)) dut (
    .CLKDIVH2(clk), .RST(rst), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
`ifdef DAS_CHMASK_EN
    .cfg_en(cfg_en),
`endif
    .out_valid(out_valid), .out_data(out_data)
  );

  das_beamformer #(.NCH(5), .W(16), .DEPTH(8)) dut2 (
    .CLKDIVH2(clk), .RST(rst), .in_valid(in_valid), .in_data(in_data2),
    .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_delay(cfg_delay2),
`ifdef DAS_CHMASK_EN
    .cfg_en(cfg_en2),
`endif
    .out_valid(out_valid2), .out_data(out_data2)
  );

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [79:0] pk5(input int k);
    int v0, v1, v2, v3, v4;
    v0 = k; v1 = 2*k; v2 = 3*k; v3 = 4*k; v4 = 5*k;
    return {v4[15:0], v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
  endfunction

  task automatic check_outputs(input string tag);
    e19 = last[18:0];
    e20 = last2[19:0];
    checks++;
    assert (out_valid === pv2) else begin
      errors++;
      $error("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, pv2);
    end
    checks++;
    assert (out_data === e19) else begin
      errors++;
      $error("FAIL %s out_data: got %0d expected %0d", tag, $signed(out_data), last);
    end
    checks++;
    assert (out_valid2 === pv2) else begin
      errors++;
      $error("FAIL %s out_valid2: got %0b expected %0b", tag, out_valid2, pv2);
    end
    checks++;
    assert (out_data2 === e20) else begin
      errors++;
      $error("FAIL %s out_data2: got %0d expected %0d", tag, $signed(out_data2), last2);
    end
  endtask

  // One clock: drive a sample (or idle), then check the output due from two cycles back
  task automatic cyc(input logic v, input logic [63:0] d, input int e, input int e2, input string tag);
    in_valid = v;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pv2 = pv1; pe2 = pe1; pe2b = pe1b;
    pv1 = v;   pe1 = e;   pe1b = e2;
    if (pv2) begin
      last  = pe2;
      last2 = pe2b;
    end
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    cfg_we2 = 1'b0;
    #1;
    pv1 = 1'b0; pv2 = 1'b0; last = 0; last2 = 0;
    check_outputs(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cfgw(input logic [1:0] ch, input logic [2:0] dly, input logic en);
    cfg_we = 1'b1; cfg_ch = ch; cfg_delay = dly; cfg_en = en;
    cyc(1'b0, '0, 0, 0, "cfg");
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0; cfg_en = 1'b1;
    in_data2 = '0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_delay2 = '0; cfg_en2 = 1'b1;
    pv1 = 1'b0; pv2 = 1'b0; pe1 = 0; pe2 = 0; pe1b = 0; pe2b = 0; last = 0; last2 = 0;
    @(negedge clk);
    do_reset("reset");

    // single sample, all delays 0
    cyc(1'b1, pk(100, 200, -50, 1), 251, 0, "t1");
    cyc(1'b0, '0, 0, 0, "t1_early");
    cyc(1'b0, '0, 0, 0, "t1_sum");
    cyc(1'b0, '0, 0, 0, "t1_hold");

    // fill gating on a 3-sample delay
    do_reset("t2_rst");
    cfgw(2'd1, 3'd3, 1'b1);
    for (int k = 1; k <= 6; k++) cyc(1'b1, pk(0, k, 0, 0), (k >= 4) ? k - 3 : 0, 0, "t2_ramp");
    cyc(1'b0, '0, 0, 0, "t2_d1");
    cyc(1'b0, '0, 0, 0, "t2_d2");

    // full-scale extremes
    do_reset("t3_rst");
    cyc(1'b1, pk(-32768, -32768, -32768, -32768), -131072, 0, "t3_min");
    cyc(1'b1, pk(32767, 32767, 32767, 32767), 131068, 0, "t3_max");
    cyc(1'b0, '0, 0, 0, "t3_d1");
    cyc(1'b0, '0, 0, 0, "t3_d2");

    // max delay across two pointer wraps; ch0 bypass rides along
    do_reset("t4_rst");
    cfgw(2'd2, 3'd7, 1'b1);
    for (int k = 1; k <= 20; k++)
      cyc(1'b1, pk(k, 0, 10*k, 0), k + ((k >= 8) ? 10*(k - 7) : 0), 0, "t4_wrap");
    cyc(1'b0, '0, 0, 0, "t4_d1");
    cyc(1'b0, '0, 0, 0, "t4_d2");

    // delay change coinciding with a sample
    do_reset("t5_rst");
    cyc(1'b1, pk(3, 0, 0, 0), 3, 0, "t5_a");
    cyc(1'b1, pk(4, 0, 0, 0), 4, 0, "t5_b");
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_delay = 3'd2; cfg_en = 1'b1;
    cyc(1'b1, pk(5, 0, 0, 0), 5, 0, "t5_same");
    cfg_we = 1'b0;
    cyc(1'b1, pk(6, 0, 0, 0), 4, 0, "t5_new1");
    cyc(1'b1, pk(7, 0, 0, 0), 5, 0, "t5_new2");
    cyc(1'b0, '0, 0, 0, "t5_d1");
    cyc(1'b0, '0, 0, 0, "t5_d2");

    // out-of-range channel write on the NCH=5 instance
    do_reset("t5b_rst");
    cfg_we2 = 1'b1; cfg_ch2 = 3'd5; cfg_delay2 = 3'd3; cfg_en2 = 1'b0;
    cyc(1'b0, '0, 0, 0, "t5b_cfg");
    cfg_we2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_data2 = pk5(k);
      cyc(1'b1, '0, 0, 15*k, "t5b_ch5");
    end
    in_data2 = '0;
    cyc(1'b0, '0, 0, 0, "t5b_d1");
    cyc(1'b0, '0, 0, 0, "t5b_d2");

    // reset while a sample is in flight
    do_reset("t6_rst0");
    cfgw(2'd1, 3'd3, 1'b1);
    cyc(1'b1, pk(1, 2, 3, 4), 8, 0, "t6_in");
    do_reset("t6_mid");
    cyc(1'b0, '0, 0, 0, "t6_drop1");
    cyc(1'b0, '0, 0, 0, "t6_drop2");
    cyc(1'b1, pk(1, 2, 3, 4), 10, 0, "t6_dly0");
    cyc(1'b0, '0, 0, 0, "t6_d1");
    cyc(1'b0, '0, 0, 0, "t6_d2");

`ifdef DAS_CHMASK_EN
    do_reset("mask_rst");
    cfgw(2'd3, 3'd0, 1'b0);
    cyc(1'b1, pk(1, 2, 3, 4), 6, 0, "mask");
    cyc(1'b0, '0, 0, 0, "mask_d1");
    cyc(1'b0, '0, 0, 0, "mask_d2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
